bus_stall_gen: RTL

- Generates the `inhibit` back-pressure signal for an arilla bus in the simulation and verification harness, replacing hand-written inhibit waveforms.
- Sits directly upstream of the bus interface. Its `inhibit` output drives `bus_interface.inhibit`, which the core and memory consume.
- Supports four stall patterns: off, periodic, pseudo-random and one-shot burst.
- A forward-progress watchdog guarantees that the bus is never stalled indefinitely.

---
 rtl/bus_stall_gen_if.sv | 47 ++++
 rtl/bus_stall_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bus_stall_gen_if.sv
// Stall-generator bus bundle: configuration in, inhibit/busy out.
// master = harness side, slave = bus_stall_gen side.
interface bus_stall_gen_if #(
  parameter int CountWidth = 8
);
  logic [1:0]            mode;
  logic [CountWidth-1:0] on_cycles;
  logic [CountWidth-1:0] off_cycles;
  logic [7:0]            density;
  logic                  start;
  logic [15:0]           seed;
  logic                  seed_load;
  logic [CountWidth-1:0] max_stall;
  logic                  inhibit;
  logic                  busy;
`ifdef BUS_STALL_GEN_STATS_EN
  logic [31:0]           stall_count;

  modport master (
    output mode, on_cycles, off_cycles,
    output density, start, seed, seed_load,
    output max_stall,
    input  inhibit, busy, stall_count
  );

  modport slave (
    input  mode, on_cycles, off_cycles,
    input  density, start, seed, seed_load,
    input  max_stall,
    output inhibit, busy, stall_count
  );
`else
  modport master (
    output mode, on_cycles, off_cycles,
    output density, start, seed, seed_load,
    output max_stall,
    input  inhibit, busy
  );

  modport slave (
    input  mode, on_cycles, off_cycles,
    input  density, start, seed, seed_load,
    input  max_stall,
    output inhibit, busy
  );
`endif
endinterface

// File: rtl/bus_stall_gen.sv
// Inhibit back-pressure generator: OFF / PERIODIC / RANDOM / BURST
// patterns with a forward-progress watchdog. Ports: clk, rst_n, bus
// (slave modport: mode, on_cycles, off_cycles, density, start, seed,
// seed_load, max_stall in; inhibit, busy out). Optional macro
// BUS_STALL_GEN_STATS_EN adds the 32-bit stall_count output.
module bus_stall_gen #(
  parameter logic [15:0] LfsrSeed   = 16'hACE1,
  parameter int          CountWidth = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_stall_gen_if.slave bus
);

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_PER = 2'd1;
  localparam logic [1:0] M_RND = 2'd2;
  localparam logic [1:0] M_BST = 2'd3;

  localparam logic PH_ON  = 1'b0;
  localparam logic PH_OFF = 1'b1;

  typedef logic [CountWidth-1:0] cnt_t;

  logic [1:0] mode_q;
  cnt_t       cnt_q, cnt_n;
  logic       ph_q, ph_n;
  cnt_t       run_q, run_n;
  logic [15:0] lfsr_q, lfsr_n;
  logic       inh_q, inh_n;
  logic       busy_q, busy_n;

  logic chg;
  logic pat;
  logic eff_on;
  logic frc;
  cnt_t on_last;
  cnt_t off_last;

  assign chg      = (bus.mode != mode_q);
  assign on_last  = bus.on_cycles - cnt_t'(1);
  assign off_last = bus.off_cycles - cnt_t'(1);
  // An empty OFF phase collapses into back-to-back ON phases.
  assign eff_on   = (ph_q == PH_ON) || (bus.off_cycles == '0);

  always_comb begin
    pat    = 1'b0;
    cnt_n  = cnt_q;
    ph_n   = ph_q;
    busy_n = busy_q;
    unique case (1'b1)
      chg || (mode_q == M_OFF): begin
        cnt_n  = '0;
        ph_n   = PH_ON;
        busy_n = 1'b0;
      end
      !chg && (mode_q == M_PER): begin
        if (bus.on_cycles == '0) begin
          cnt_n = '0;
          ph_n  = PH_ON;
        end else if (eff_on) begin
          pat = 1'b1;
          if (cnt_q >= on_last) begin
            cnt_n = '0;
            ph_n  = (bus.off_cycles == '0) ? PH_ON : PH_OFF;
          end else begin
            cnt_n = cnt_q + cnt_t'(1);
            ph_n  = PH_ON;
          end
        end else begin
          if (cnt_q >= off_last) begin
            cnt_n = '0;
            ph_n  = PH_ON;
          end else begin
            cnt_n = cnt_q + cnt_t'(1);
          end
        end
      end
      !chg && (mode_q == M_RND): begin
        pat    = (lfsr_q[7:0] < bus.density);
        cnt_n  = '0;
        ph_n   = PH_ON;
        busy_n = 1'b0;
      end
      !chg && (mode_q == M_BST): begin
        ph_n = PH_ON;
        if (busy_q) begin
          if ((bus.on_cycles == '0) || (cnt_q >= on_last)) begin
            busy_n = 1'b0;
            cnt_n  = '0;
          end else begin
            pat   = 1'b1;
            cnt_n = cnt_q + cnt_t'(1);
          end
        end else if (bus.start && (bus.on_cycles != '0)) begin
          pat    = 1'b1;
          busy_n = 1'b1;
          cnt_n  = '0;
        end
      end
      default: begin
        cnt_n = '0;
      end
    endcase
  end

  // run_q holds the length of the high run currently on inhibit.
  assign frc   = (bus.max_stall != '0) && (run_q == bus.max_stall);
  assign inh_n = pat && !frc && !chg;

  always_comb begin
    run_n = '0;
    if (inh_n) begin
      run_n = (run_q == '1) ? run_q : run_q + cnt_t'(1);
    end
  end

  always_comb begin
    lfsr_n = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (bus.seed_load) begin
      lfsr_n = (bus.seed == 16'h0000) ? LfsrSeed : bus.seed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_OFF;
      cnt_q  <= '0;
      ph_q   <= PH_ON;
      run_q  <= '0;
      lfsr_q <= LfsrSeed;
      inh_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      cnt_q  <= cnt_n;
      ph_q   <= ph_n;
      run_q  <= run_n;
      lfsr_q <= lfsr_n;
      inh_q  <= inh_n;
      busy_q <= busy_n;
    end
  end

  assign bus.inhibit = inh_q;
  assign bus.busy    = busy_q;

`ifdef BUS_STALL_GEN_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (bus.seed_load) begin
      stall_q <= '0;
    end else if (inh_q) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_q;
`endif

endmodule
